// File: rtl/beat_pkg.sv
// beat_pkg: shared FSM state type, beat-code constants and the whole-note
// cycle-count helper for the beat_timer block.
package beat_pkg;

    // Timer FSM states; encoding is visible on beat_timer.dbg_state.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_GAP  = 2'd2
    } beat_state_e;

    // Beat codes: duration = whole note >> code.
    localparam logic [3:0] BEAT_1  = 4'd0;
    localparam logic [3:0] BEAT_2  = 4'd1;
    localparam logic [3:0] BEAT_4  = 4'd2;
    localparam logic [3:0] BEAT_8  = 4'd3;
    localparam logic [3:0] BEAT_16 = 4'd4;
    localparam logic [3:0] BEAT_32 = 4'd5;
    localparam logic [3:0] BEAT_64 = 4'd6;

    // Clock cycles in one whole note; divide first so the product stays small.
    function automatic longint unsigned whole_cnt(input longint unsigned clk_hz,
                                                  input longint unsigned whole_ms);
        return (clk_hz / 64'd1000) * whole_ms;
    endfunction

endpackage

// File: rtl/beat_len_calc.sv
// beat_len_calc: combinational beat code (+ optional dotted) to note length.
// Codes above MAX_LOG2 are flagged invalid and given a one-cycle length.
// Optional feature macro: BEAT_TIMER_DOTTED_EN (dotted adds half a note).
module beat_len_calc
    import beat_pkg::*;
#(
    parameter longint unsigned WHOLE_CNT = 64,
    parameter int              CNT_W     = 28,
    parameter int              MAX_LOG2  = 6
) (
    input  logic [3:0]       beat_i,
    input  logic             dotted_i,
    output logic [CNT_W-1:0] len_o,
    output logic             invalid_o
);

    localparam logic [CNT_W-1:0] WHOLE = CNT_W'(WHOLE_CNT);

    logic [CNT_W-1:0] base;

`ifdef BEAT_TIMER_DOTTED_EN
    logic [4:0] beat_p1;
    assign beat_p1 = {1'b0, beat_i} + 5'd1;
`else
    // Dotted notes are not built in; the input is deliberately ignored.
    logic unused_dotted;
    assign unused_dotted = dotted_i;
`endif

    // Length from the beat shift, forced to one cycle for invalid codes.
    always_comb begin
        invalid_o = (beat_i > 4'(MAX_LOG2));
        base      = WHOLE >> beat_i;
`ifdef BEAT_TIMER_DOTTED_EN
        if (dotted_i) begin
            base = base + (WHOLE >> beat_p1);
        end
`endif
        len_o = invalid_o ? CNT_W'(1) : base;
    end

endmodule

// File: rtl/beat_timer.sv
// beat_timer: note-duration timer. Accepts one note per valid/ready
// handshake, counts its length down and drives tone_en, with an optional
// articulation gap at the end of long-enough notes.
// Optional feature macro: BEAT_TIMER_DOTTED_EN (see beat_len_calc).
//
// Handshake: a note transfers in any cycle where in_valid & in_ready.
// in_ready is high when idle or on the last cycle of the current note, so
// a waiting note starts with no idle cycle in between. abort or reset
// forces in_ready low, so a note offered alongside abort is not taken.
module beat_timer
    import beat_pkg::*;
#(
    parameter int CLK_HZ     = 50_000_000,
    parameter int WHOLE_MS   = 1600,
    parameter int CNT_W      = 28,
    parameter int MAX_LOG2   = 6,
    parameter int GAP_CYCLES = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [3:0] beat,
    input  logic       rest,
    input  logic       dotted,
    input  logic       abort,
    output logic       tone_en,
    output logic       busy,
    output logic       note_done,
    output logic       err,
    output logic [1:0] dbg_state
);

    localparam longint unsigned WHOLE_CNT = whole_cnt(64'(CLK_HZ), 64'(WHOLE_MS));
    localparam logic [CNT_W:0]   GAP_TWICE = (CNT_W+1)'(2 * GAP_CYCLES);
    localparam logic [CNT_W-1:0] GAP_CNT   = CNT_W'(GAP_CYCLES);
    localparam bit               GAP_ON    = (GAP_CYCLES != 0);

    beat_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rest_q, rest_d;
    logic             inv_q, inv_d;
    logic             gap_q, gap_d;
    logic             tone_q, tone_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             errp_q, errp_d;

    logic [CNT_W-1:0] len;
    logic             len_invalid;
    logic             gap_ok;
    logic             accept;

    beat_len_calc #(
        .WHOLE_CNT (WHOLE_CNT),
        .CNT_W     (CNT_W),
        .MAX_LOG2  (MAX_LOG2)
    ) u_len (
        .beat_i    (beat),
        .dotted_i  (dotted),
        .len_o     (len),
        .invalid_o (len_invalid)
    );

    assign gap_ok   = GAP_ON && ({1'b0, len} > GAP_TWICE);
    assign in_ready = rst_n && !abort && (state_q == ST_IDLE || cnt_q == '0);
    assign accept   = in_valid && in_ready;

    // Next state, counter, latched note flags and next output values.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rest_d  = rest_q;
        inv_d   = inv_q;
        gap_d   = gap_q;
        if (abort) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        state_d = ST_PLAY;
                        cnt_d   = len - CNT_W'(1);
                        rest_d  = rest;
                        inv_d   = len_invalid;
                        gap_d   = gap_ok;
                    end
                end
                ST_PLAY, ST_GAP: begin
                    if (cnt_q == '0) begin
                        if (accept) begin
                            state_d = ST_PLAY;
                            cnt_d   = len - CNT_W'(1);
                            rest_d  = rest;
                            inv_d   = len_invalid;
                            gap_d   = gap_ok;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                        // Tone drops for the final GAP_CYCLES cycles.
                        if (state_q == ST_PLAY && gap_q && cnt_q == GAP_CNT) begin
                            state_d = ST_GAP;
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
        tone_d = (state_d == ST_PLAY) && !rest_d && !inv_d;
        busy_d = (state_d != ST_IDLE);
        done_d = (state_d != ST_IDLE) && (cnt_d == '0);
        errp_d = done_d && inv_d;
    end

    // State, counter, flags and registered outputs; synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            rest_q  <= 1'b0;
            inv_q   <= 1'b0;
            gap_q   <= 1'b0;
            tone_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            errp_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rest_q  <= rest_d;
            inv_q   <= inv_d;
            gap_q   <= gap_d;
            tone_q  <= tone_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            errp_q  <= errp_d;
        end
    end

    assign tone_en   = tone_q;
    assign busy      = busy_q;
    assign note_done = done_q;
    assign err       = errp_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_beat_timer.sv
// tb_beat_timer: self-checking bench for beat_timer with WHOLE_CNT=64 and a
// two-cycle articulation gap. A note-level model expands every accepted note
// into its expected per-cycle outputs; directed scenarios pin the model with
// hand-computed literals, then random traffic runs against the model.
module tb_beat_timer;

    localparam int CLK_HZ     = 1000;
    localparam int WHOLE_MS   = 64;
    localparam int CNT_W      = 28;
    localparam int MAX_LOG2   = 6;
    localparam int GAP_CYCLES = 2;
`ifdef BEAT_TIMER_DOTTED_EN
    localparam int DOT_LEN = 12;
`else
    localparam int DOT_LEN = 8;
`endif

    // ---------------- clock / reset / DUT ----------------
    logic       clk = 1'b0;
    logic       rst_n, in_valid, rest, dotted, abort;
    logic [3:0] beat;
    logic       in_ready, tone_en, busy, note_done, err;
    logic [1:0] dbg_state;

    always #5 clk = ~clk;

    beat_timer #(
        .CLK_HZ     (CLK_HZ),
        .WHOLE_MS   (WHOLE_MS),
        .CNT_W      (CNT_W),
        .MAX_LOG2   (MAX_LOG2),
        .GAP_CYCLES (GAP_CYCLES)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .beat      (beat),
        .rest      (rest),
        .dotted    (dotted),
        .abort     (abort),
        .tone_en   (tone_en),
        .busy      (busy),
        .note_done (note_done),
        .err       (err),
        .dbg_state (dbg_state)
    );

    int n_checks = 0;
    int n_errors = 0;
    bit started  = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Each entry is one expected cycle of a note: {tone_en, note_done, err}.
    logic [2:0] exp_q[$];

    function automatic int note_len(input int b, input bit d);
        int whole;
        int n;
        bit dot_on;
`ifdef BEAT_TIMER_DOTTED_EN
        dot_on = 1'b1;
`else
        dot_on = 1'b0;
`endif
        whole = CLK_HZ / 1000 * WHOLE_MS;
        if (b > MAX_LOG2) return 1;
        n = whole / (1 << b);
        if (d && dot_on) n = n + whole / (1 << (b + 1));
        return n;
    endfunction

    task automatic push_note(input int b, input bit r, input bit d);
        int  len;
        bit  inv;
        bit  gap;
        bit  t;
        len = note_len(b, d);
        inv = (b > MAX_LOG2);
        gap = (GAP_CYCLES != 0) && (len > 2 * GAP_CYCLES);
        for (int k = 1; k <= len; k++) begin
            t = !r && !inv && !(gap && k > len - GAP_CYCLES);
            exp_q.push_back({t, (k == len), (inv && k == len)});
        end
    endtask

    // Compare every cycle, then advance the model across the coming edge.
    always @(negedge clk) begin
        logic [2:0] cur;
        bit         ready_exp;
        bit         busy_exp;
        cur       = (exp_q.size() > 0) ? exp_q[0] : 3'b000;
        busy_exp  = (exp_q.size() > 0);
        ready_exp = rst_n && !abort && (exp_q.size() <= 1);
        if (started) begin
            chk("in_ready",  in_ready,  ready_exp);
            chk("busy",      busy,      busy_exp);
            chk("tone_en",   tone_en,   cur[2]);
            chk("note_done", note_done, cur[1]);
            chk("err",       err,       cur[0]);
        end
        if (!rst_n || abort) begin
            exp_q.delete();
        end else begin
            if (exp_q.size() > 0) void'(exp_q.pop_front());
            if (in_valid && ready_exp) push_note(int'(beat), rest, dotted);
        end
    end

    // ---------------- activity monitor for literal checks ----------------
    int mon_cyc = 0, mon_busy = 0, mon_tone = 0, mon_err = 0;
    int done_cyc_q[$];
    int s_cyc, s_busy, s_tone, s_err, s_done;

    always @(negedge clk) begin
        mon_cyc++;
        if (busy === 1'b1) mon_busy++;
        if (tone_en === 1'b1) mon_tone++;
        if (err === 1'b1) mon_err++;
        if (note_done === 1'b1) done_cyc_q.push_back(mon_cyc);
    end

    task automatic snap();
        s_cyc  = mon_cyc;
        s_busy = mon_busy;
        s_tone = mon_tone;
        s_err  = mon_err;
        s_done = done_cyc_q.size();
    endtask

    // Cycle indices are relative to the snap: 1 = first cycle of the note.
    task automatic expect_note(input string tag, input int n_busy, input int n_tone,
                               input int n_err, input int n_done,
                               input int first_done, input int last_done);
        int got_done;
        got_done = done_cyc_q.size() - s_done;
        chk({tag, "_busy_cycles"}, mon_busy - s_busy, n_busy);
        chk({tag, "_tone_cycles"}, mon_tone - s_tone, n_tone);
        chk({tag, "_err_pulses"},  mon_err - s_err,   n_err);
        chk({tag, "_done_pulses"}, got_done,          n_done);
        if (got_done > 0 && n_done > 0) begin
            chk({tag, "_first_done"}, done_cyc_q[s_done] - s_cyc, first_done);
            chk({tag, "_last_done"},  done_cyc_q[$] - s_cyc,      last_done);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Offer a note and return just after the edge that accepted it.
    task automatic offer(input logic [3:0] b, input logic r, input logic d);
        int waited;
        waited   = 0;
        beat     = b;
        rest     = r;
        dotted   = d;
        in_valid = 1'b1;
        @(negedge clk);
        while (in_ready !== 1'b1 && waited < 300) begin
            waited++;
            @(negedge clk);
        end
        if (waited >= 300) begin
            n_checks++;
            n_errors++;
            $display("FAIL offer_timeout: got no in_ready expected in_ready within 300 cycles at %0t", $time);
        end
        @(posedge clk);
        #1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        beat     = 4'd0;
        rest     = 1'b0;
        dotted   = 1'b0;
        abort    = 1'b0;
        @(posedge clk);
        #1;
        started = 1'b1;
        @(negedge clk);
        chk("reset_in_ready", in_ready, 0);
        chk("reset_busy",     busy,     0);
        chk("reset_tone_en",  tone_en,  0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("release_in_ready", in_ready, 1);
        @(posedge clk);
        #1;

        // Quarter note: 16 cycles, tone off for the last two.
        offer(4'd2, 1'b0, 1'b0);
        in_valid = 1'b0;
        snap();
        wait_cycles(20);
        expect_note("quarter", 16, 14, 0, 1, 16, 16);

        // Back-to-back 1/16 and 1/32: too short for a gap, no idle between.
        offer(4'd4, 1'b0, 1'b0);
        snap();
        offer(4'd5, 1'b0, 1'b0);
        in_valid = 1'b0;
        wait_cycles(10);
        expect_note("b2b", 6, 6, 0, 2, 4, 6);

        // Dotted eighth (only lengthened when the feature is built in).
        offer(4'd3, 1'b0, 1'b1);
        in_valid = 1'b0;
        dotted   = 1'b0;
        snap();
        wait_cycles(16);
        expect_note("dotted", DOT_LEN, DOT_LEN - 2, 0, 1, DOT_LEN, DOT_LEN);

        // Eighth rest: timed but silent.
        offer(4'd3, 1'b1, 1'b0);
        in_valid = 1'b0;
        rest     = 1'b0;
        snap();
        wait_cycles(12);
        expect_note("rest", 8, 0, 0, 1, 8, 8);

        // Invalid beat code: one silent cycle with err.
        offer(4'd9, 1'b0, 1'b0);
        in_valid = 1'b0;
        snap();
        wait_cycles(4);
        expect_note("invalid", 1, 0, 1, 1, 1, 1);

        // Abort in cycle 5 of a half note while another note is offered.
        offer(4'd1, 1'b0, 1'b0);
        snap();
        wait_cycles(4);
        abort = 1'b1;
        @(negedge clk);
        chk("abort_in_ready", in_ready, 0);
        @(posedge clk);
        #1;
        abort    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("abort_busy",     busy,     0);
        chk("abort_tone_en",  tone_en,  0);
        chk("abort_in_ready", in_ready, 1);
        @(posedge clk);
        #1;
        chk("abort_no_done", done_cyc_q.size() - s_done, 0);

        // Reset in the middle of a note.
        offer(4'd1, 1'b0, 1'b0);
        in_valid = 1'b0;
        wait_cycles(6);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_in_ready_low", in_ready, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_busy",     busy,      0);
        chk("midrst_tone_en",  tone_en,   0);
        chk("midrst_done",     note_done, 0);
        chk("midrst_in_ready", in_ready,  1);
        @(posedge clk);
        #1;

        // Random traffic checked cycle by cycle against the model.
        for (int i = 0; i < 3000; i++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            beat     = 4'($urandom_range(0, 9));
            if ($urandom_range(0, 15) == 0) beat = 4'($urandom_range(7, 15));
            rest     = ($urandom_range(0, 4) == 0);
            dotted   = $urandom_range(0, 1) != 0;
            abort    = ($urandom_range(0, 49) == 0);
            rst_n    = ($urandom_range(0, 599) != 0);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        abort    = 1'b0;
        rst_n    = 1'b1;
        wait_cycles(120);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Global time bound.
    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion at %0t", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
